rx_pfc_pause: RTL and testbench

RX_PFC_PAUSE -- requirements
Module: rx_pfc_pause

---
 rtl/rx_pfc_pause.sv | 156 +++++++++++++++
 tb/tb_rx_pfc_pause.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_pfc_pause.sv
// Receive-side 802.3x / 802.1Qbb pause parser with per-class 16-bit quanta countdown.
// Latency: counts load on the tlast edge, rx_pause_active follows one edge later; no backpressure (AXIS has no tready).
module rx_pfc_pause #(
    parameter int NUM_CLASSES    = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic [63:0]               tdata_i,
    input  logic [7:0]                tkeep_i,
    input  logic                      tvalid_i,
    input  logic                      tlast_i,
    input  logic                      tuser_i,
    output logic                      tuser_o,
    input  logic                      cfg_rx_pause_enable,
    input  logic                      cfg_pfc_mode,
    input  logic                      cfg_drop_ctrl,
    input  logic [PRESCALE_WIDTH-1:0] cfg_sub_quanta_count,
    output logic [NUM_CLASSES-1:0]    rx_pause_active
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_B2   = 3'd2;
    localparam logic [2:0] S_B3   = 3'd3;
    localparam logic [2:0] S_B4   = 3'd4;
    localparam logic [2:0] S_WAIT = 3'd5;
    localparam logic [2:0] S_SKIP = 3'd6;

    logic [2:0]                state;
    logic                      pfc_q;
    logic                      op_ok_q;
    logic                      load_pend;
    logic [7:0]                en_q;
    logic [15:0]               time_q [8];
    logic [15:0]               count_q [NUM_CLASSES];
    logic [PRESCALE_WIDTH-1:0] sub_q;
    logic [PRESCALE_WIDTH-1:0] sub_last;
    logic [NUM_CLASSES-1:0]    cnt_nz;
    logic                      any_nz;
    logic                      tick;
    logic                      is_ctrl;
    logic                      load_fire;
    logic                      da_match;
    logic                      et_match;
    logic [15:0]               opcode;
    logic                      unused_keep;

    function automatic logic [15:0] be16(input logic [15:0] x);
        return {x[7:0], x[15:8]};
    endfunction

    assign unused_keep = ^tkeep_i;

    assign da_match = (tdata_i[47:0] == 48'h0100_00C2_8001);
    assign et_match = (tdata_i[47:32] == 16'h0888);
    assign opcode   = be16(tdata_i[63:48]);

    // A frame counts as control once its EtherType beat has matched, including that beat itself.
    assign is_ctrl = (state == S_B2) || (state == S_B3) || (state == S_B4) ||
                     (state == S_WAIT) || ((state == S_HDR) && et_match);

    assign tuser_o = tuser_i & ~(cfg_drop_ctrl & tvalid_i & tlast_i & is_ctrl);

    assign load_fire = tvalid_i & tlast_i & (state == S_WAIT) & load_pend &
                       tuser_i & cfg_rx_pause_enable;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            pfc_q     <= 1'b0;
            op_ok_q   <= 1'b0;
            load_pend <= 1'b0;
            en_q      <= '0;
            for (int i = 0; i < 8; i++) time_q[i] <= '0;
        end else if (tvalid_i) begin
            if (tlast_i) begin
                state     <= S_IDLE;
                load_pend <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: state <= da_match ? S_HDR : S_SKIP;
                    S_HDR: begin
                        if (et_match) begin
                            state     <= S_B2;
                            pfc_q     <= cfg_pfc_mode;
                            op_ok_q   <= cfg_pfc_mode ? (opcode == 16'h0101) : (opcode == 16'h0001);
                            load_pend <= 1'b0;
                        end else begin
                            state <= S_SKIP;
                        end
                    end
                    S_B2: begin
                        if (!op_ok_q) begin
                            state <= S_WAIT;
                        end else if (!pfc_q) begin
                            for (int i = 0; i < 8; i++) time_q[i] <= be16(tdata_i[15:0]);
                            en_q      <= 8'hFF;
                            load_pend <= 1'b1;
                            state     <= S_WAIT;
                        end else begin
                            en_q      <= tdata_i[15:8];
                            time_q[0] <= be16(tdata_i[31:16]);
                            time_q[1] <= be16(tdata_i[47:32]);
                            time_q[2] <= be16(tdata_i[63:48]);
                            state     <= S_B3;
                        end
                    end
                    S_B3: begin
                        time_q[3] <= be16(tdata_i[15:0]);
                        time_q[4] <= be16(tdata_i[31:16]);
                        time_q[5] <= be16(tdata_i[47:32]);
                        time_q[6] <= be16(tdata_i[63:48]);
                        state     <= S_B4;
                    end
                    S_B4: begin
                        time_q[7] <= be16(tdata_i[15:0]);
                        load_pend <= 1'b1;
                        state     <= S_WAIT;
                    end
                    S_WAIT, S_SKIP: state <= state;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        cnt_nz = '0;
        for (int i = 0; i < NUM_CLASSES; i++) cnt_nz[i] = (count_q[i] != 16'd0);
    end

    assign any_nz   = |cnt_nz;
    // A programmed prescale of 0 behaves as 1, i.e. a tick every clock.
    assign sub_last = (cfg_sub_quanta_count == '0) ? '0
                    : cfg_sub_quanta_count - PRESCALE_WIDTH'(1);
    assign tick     = cfg_rx_pause_enable & any_nz & (sub_q == sub_last);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sub_q           <= '0;
            rx_pause_active <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) count_q[i] <= '0;
        end else begin
            if (!cfg_rx_pause_enable || !any_nz || tick) sub_q <= '0;
            else                                         sub_q <= sub_q + PRESCALE_WIDTH'(1);
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (!cfg_rx_pause_enable)          count_q[i] <= '0;
                else if (load_fire && en_q[i])     count_q[i] <= time_q[i];
                else if (tick && cnt_nz[i])        count_q[i] <= count_q[i] - 16'd1;
            end
            rx_pause_active <= cnt_nz;
        end
    end

endmodule

// File: tb/tb_rx_pfc_pause.sv
// Scoreboard bench for rx_pfc_pause: expectations are queued by stimulus, popped by a negedge monitor.
module tb_rx_pfc_pause;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [63:0] tdata_i;
    logic [7:0]  tkeep_i;
    logic        tvalid_i, tlast_i, tuser_i;
    logic        tuser_o;
    logic        cfg_rx_pause_enable, cfg_pfc_mode, cfg_drop_ctrl;
    logic [7:0]  cfg_sub_quanta_count;
    logic [7:0]  rx_pause_active;

    rx_pfc_pause #(.NUM_CLASSES(8), .PRESCALE_WIDTH(8)) dut (
        .clk(clk), .aresetn(aresetn), .tdata_i(tdata_i), .tkeep_i(tkeep_i),
        .tvalid_i(tvalid_i), .tlast_i(tlast_i), .tuser_i(tuser_i), .tuser_o(tuser_o),
        .cfg_rx_pause_enable(cfg_rx_pause_enable), .cfg_pfc_mode(cfg_pfc_mode),
        .cfg_drop_ctrl(cfg_drop_ctrl), .cfg_sub_quanta_count(cfg_sub_quanta_count),
        .rx_pause_active(rx_pause_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] act;
    } exp_t;

    exp_t        sbq[$];
    logic        tuq[$];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    logic [63:0] fr [8];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: tuser_o on every tlast beat, rx_pause_active at each scheduled cycle.
    always @(negedge clk) begin
        exp_t x;
        logic e;
        if (tvalid_i && tlast_i) begin
            checks++;
            if (tuq.size() == 0) begin
                $display("FAIL tuser_unexpected: tlast beat at cyc %0d with no expectation queued", cyc);
            end else begin
                e = tuq.pop_front();
                if (tuser_o === e) passes++;
                else $display("FAIL tuser_o at cyc %0d: got %b want %b", cyc, tuser_o, e);
            end
        end
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            x = sbq.pop_front();
            checks++;
            if (x.cyc < cyc)
                $display("FAIL pause_late: entry for cyc %0d seen at cyc %0d", x.cyc, cyc);
            else if (rx_pause_active === x.act)
                passes++;
            else
                $display("FAIL rx_pause_active at cyc %0d: got %02h want %02h", cyc, rx_pause_active, x.act);
        end
    end

    function automatic logic [15:0] be16(input logic [15:0] x);
        return {x[7:0], x[15:8]};
    endfunction

    task automatic expect_at(input int c, input logic [7:0] v);
        sbq.push_back('{cyc: c, act: v});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic build_hdr(input logic [15:0] op);
        for (int i = 0; i < 8; i++) fr[i] = 64'h0;
        fr[0] = {16'h1122, 48'h0100_00C2_8001};
        fr[1] = {be16(op), 16'h0888, 32'h3344_5566};
    endtask

    task automatic build_classic(input logic [15:0] op, input logic [15:0] q);
        build_hdr(op);
        fr[2] = {48'h0, be16(q)};
    endtask

    task automatic build_pfc(input logic [7:0] en, input logic [15:0] t0, input logic [15:0] t2);
        build_hdr(16'h0101);
        fr[2] = {be16(t2), be16(16'h0007), be16(t0), en, 8'h00};
        fr[3] = {4{be16(16'h0123)}};
        fr[4] = {48'h0, be16(16'h0123)};
    endtask

    task automatic build_plain();
        for (int i = 0; i < 8; i++) fr[i] = 64'h0;
        fr[0] = {16'h1122, 48'h5544_3322_1100};
        fr[1] = {be16(16'h0001), 16'h0888, 32'h3344_5566};
        fr[2] = {48'h0, be16(16'h0003)};
    endtask

    task automatic send_frame(input int n, input logic user, input logic exp_user, output int t);
        for (int i = 0; i < n; i++) begin
            tdata_i  = fr[i];
            tvalid_i = 1'b1;
            tlast_i  = (i == n - 1);
            tuser_i  = user;
            if (i == n - 1) tuq.push_back(exp_user);
            @(posedge clk);
            #1;
        end
        tvalid_i = 1'b0;
        tlast_i  = 1'b0;
        tuser_i  = 1'b0;
        t = cyc;
    endtask

    initial begin
        int t;
        int cur;
        aresetn = 1'b0;
        tdata_i = '0; tkeep_i = 8'hFF; tvalid_i = 1'b0; tlast_i = 1'b0; tuser_i = 1'b0;
        cfg_rx_pause_enable = 1'b1; cfg_pfc_mode = 1'b0; cfg_drop_ctrl = 1'b0;
        cfg_sub_quanta_count = 8'd8;
        idle(3);
        aresetn = 1'b1;
        expect_at(cyc + 1, 8'h00);
        idle(3);

        // Classic pause, quanta 3 at 8 clocks/quantum: 24 active cycles.
        build_classic(16'h0001, 16'd3);
        send_frame(8, 1'b1, 1'b1, t);
        expect_at(t, 8'h00); expect_at(t + 1, 8'hFF); expect_at(t + 24, 8'hFF); expect_at(t + 25, 8'h00);
        idle(30);

        // PFC: class 0 for 2 quanta, class 2 for 256 quanta; class 1 has a time but no enable.
        cfg_pfc_mode = 1'b1;
        build_pfc(8'h05, 16'd2, 16'h0100);
        send_frame(8, 1'b1, 1'b1, t);
        expect_at(t + 1, 8'h05); expect_at(t + 16, 8'h05); expect_at(t + 17, 8'h04);
        expect_at(t + 2048, 8'h04); expect_at(t + 2049, 8'h00);
        idle(2055);

        // Bad CRC: no load, tuser passes through as 0.
        send_frame(8, 1'b0, 1'b0, t);
        expect_at(t + 1, 8'h00); expect_at(t + 20, 8'h00);
        idle(22);

        // Dropping: opcode/mode mismatch still drops but loads nothing; non-control frame untouched.
        cfg_drop_ctrl = 1'b1;
        build_classic(16'h0001, 16'd3);
        send_frame(8, 1'b1, 1'b0, t);
        expect_at(t + 1, 8'h00); expect_at(t + 4, 8'h00);
        build_plain();
        send_frame(8, 1'b1, 1'b1, t);
        expect_at(t + 1, 8'h00);
        idle(3);
        cfg_drop_ctrl = 1'b0;

        // XON: time 0 on a paused class releases it right away.
        build_pfc(8'h01, 16'd100, 16'd0);
        send_frame(8, 1'b1, 1'b1, t);
        expect_at(t + 1, 8'h01);
        idle(10);
        build_pfc(8'h01, 16'd0, 16'd0);
        send_frame(8, 1'b1, 1'b1, t);
        expect_at(t, 8'h01); expect_at(t + 1, 8'h00); expect_at(t + 5, 8'h00);
        idle(6);

        // Runt control frame, then a non-control frame, then a good pause frame.
        cfg_pfc_mode = 1'b0;
        build_classic(16'h0001, 16'd3);
        send_frame(2, 1'b1, 1'b1, t);
        expect_at(t + 1, 8'h00); expect_at(t + 3, 8'h00);
        build_plain();
        send_frame(8, 1'b1, 1'b1, t);
        expect_at(t + 1, 8'h00);
        build_classic(16'h0001, 16'd1);
        send_frame(8, 1'b1, 1'b1, t);
        expect_at(t + 1, 8'hFF); expect_at(t + 8, 8'hFF); expect_at(t + 9, 8'h00);
        idle(12);

        // Prescale 0 behaves as 1.
        cfg_sub_quanta_count = 8'd0;
        build_classic(16'h0001, 16'd3);
        send_frame(8, 1'b1, 1'b1, t);
        expect_at(t + 3, 8'hFF); expect_at(t + 4, 8'h00);
        idle(6);
        cfg_sub_quanta_count = 8'd8;

        // Disabling clears counts on the next edge and blocks further loads.
        build_classic(16'h0001, 16'd50);
        send_frame(8, 1'b1, 1'b1, t);
        expect_at(t + 1, 8'hFF);
        idle(3);
        cur = cyc;
        cfg_rx_pause_enable = 1'b0;
        expect_at(cur + 1, 8'hFF); expect_at(cur + 2, 8'h00);
        idle(3);
        build_classic(16'h0001, 16'd5);
        send_frame(8, 1'b1, 1'b1, t);
        expect_at(t + 1, 8'h00); expect_at(t + 3, 8'h00);
        idle(2);
        cfg_rx_pause_enable = 1'b1;
        idle(2);

        // Reset mid-pause and mid-frame, then a clean pause frame.
        build_classic(16'h0001, 16'd20);
        send_frame(8, 1'b1, 1'b1, t);
        expect_at(t + 1, 8'hFF);
        idle(5);
        build_classic(16'h0001, 16'd5);
        for (int i = 0; i < 3; i++) begin
            tdata_i = fr[i]; tvalid_i = 1'b1; tlast_i = 1'b0; tuser_i = 1'b1;
            @(posedge clk);
            #1;
        end
        aresetn = 1'b0;
        tvalid_i = 1'b0; tuser_i = 1'b0;
        expect_at(cyc, 8'h00); expect_at(cyc + 1, 8'h00);
        idle(2);
        aresetn = 1'b1;
        idle(1);
        build_classic(16'h0001, 16'd1);
        send_frame(8, 1'b1, 1'b1, t);
        expect_at(t + 1, 8'hFF); expect_at(t + 8, 8'hFF); expect_at(t + 9, 8'h00);

        for (int k = 0; k < 3000 && sbq.size() > 0; k++) @(posedge clk);
        idle(1);
        while (sbq.size() > 0) begin
            exp_t x;
            x = sbq.pop_front();
            checks++;
            $display("FAIL pause_timeout: entry for cyc %0d (want %02h) never checked", x.cyc, x.act);
        end
        while (tuq.size() > 0) begin
            logic e;
            e = tuq.pop_front();
            checks++;
            $display("FAIL tuser_timeout: expected tuser_o %b never observed", e);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
